// File: rtl/packet_output_allocator_pkg.sv
// Shared definitions for the router output-port allocator.
//   NPORTS      number of requesting input ports (0=L,1=N,2=E,3=W,4=S)
//   IW          width of a port index
//   P_L..P_S    port index constants
//   FID_*       bit positions inside a 3-bit flit id
//   alloc_state_e  allocator FSM states
package packet_output_allocator_pkg;

  localparam int NPORTS = 5;
  localparam int IW     = 3;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  localparam int FID_HEAD = 0;
  localparam int FID_BODY = 1;
  localparam int FID_TAIL = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/packet_output_allocator_if.sv
// Bundle between the input buffers (master) and one output allocator (slave).
//   req, flit_id, credit_in   : driven by the master side
//   grant, grant_idx, xfer,
//   credits, timeout_err,
//   credit_err, state         : driven by the allocator (state is a debug view of the FSM)
//
// Handshake: input i keeps req[i] high with the same flit on flit_id[3i+2:3i]
// until the flit is consumed. A flit is consumed in exactly the cycle where
// xfer=1 and grant_idx=i; xfer already includes the credit check, so no
// separate ready is needed. credit_in is a one-cycle pulse per freed slot.
interface packet_output_allocator_if #(
  parameter int NPORTS = 5,
  parameter int CW     = 3
);
  import packet_output_allocator_pkg::*;

  logic [NPORTS-1:0]   req;
  logic [3*NPORTS-1:0] flit_id;
  logic                credit_in;
  logic [NPORTS-1:0]   grant;
  logic [2:0]          grant_idx;
  logic                xfer;
  logic [CW-1:0]       credits;
  logic                timeout_err;
  logic                credit_err;
  alloc_state_e        state;

  modport master (
    output req, flit_id, credit_in,
    input  grant, grant_idx, xfer, credits, timeout_err, credit_err, state
  );

  modport slave (
    input  req, flit_id, credit_in,
    output grant, grant_idx, xfer, credits, timeout_err, credit_err, state
  );

endinterface

// File: rtl/packet_output_allocator_rr_pick.sv
// Combinational round-robin picker.
//   cand    in   NPORTS  candidate vector
//   ptr     in   IW      last served port; search starts at ptr+1
//   winner  out  IW      first candidate found searching ptr+1, ptr+2, ... mod NPORTS
//   found   out  1       any candidate present
module packet_output_allocator_rr_pick
  import packet_output_allocator_pkg::*;
(
  input  logic [NPORTS-1:0] cand,
  input  logic [IW-1:0]     ptr,
  output logic [IW-1:0]     winner,
  output logic              found
);

  // Walk the search order backwards so the nearest candidate after ptr
  // is the last one written and therefore wins.
  always_comb begin
    logic [IW-1:0] idx;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = NPORTS; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NPORTS);
      if (cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_output_allocator.sv
// Output-port allocator: round-robin arbitration among the input ports,
// packet lock from head to tail, credit flow control toward the downstream
// buffer and a stall watchdog that frees a lock whose owner stops sending.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset
//   bus   slave modport: req/flit_id/credit_in in; grant, grant_idx,
//         xfer (combinational), credits, timeout_err, credit_err, state out
module packet_output_allocator
  import packet_output_allocator_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 64
) (
  input logic                      clk,
  input logic                      rst,
  packet_output_allocator_if.slave bus
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  alloc_state_e      state_q, state_d;
  logic [NPORTS-1:0] cand;
  logic [IW-1:0]     win_idx;
  logic              win_found;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     idx_q;
  logic [NPORTS-1:0] grant_q;
  logic [CW-1:0]     credits_q;
  logic [TW-1:0]     wd_q;
  logic              terr_q;
  logic              cerr_q;
  logic              owner_req;
  logic [2:0]        owner_fid;
  logic              xfer;
  logic              grant_now;
  logic              release_tail;
  logic              release_to;

  // Only head flits may open a packet.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cand[i] = bus.req[i] & bus.flit_id[3*i+FID_HEAD];
    end
  end

  packet_output_allocator_rr_pick u_rr_pick (
    .cand   (cand),
    .ptr    (ptr_q),
    .winner (win_idx),
    .found  (win_found)
  );

  // Request and flit id of the current owner.
  always_comb begin
    owner_req = 1'b0;
    owner_fid = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (idx_q == IW'(i)) begin
        owner_req = bus.req[i];
        owner_fid = bus.flit_id[3*i +: 3];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (win_found) state_d = ST_LOCKED;
      ST_LOCKED: if (release_tail || release_to) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and events
  always_comb begin
    xfer         = (state_q == ST_LOCKED) && owner_req && (credits_q != '0);
    grant_now    = (state_q == ST_IDLE) && win_found;
    release_tail = xfer && owner_fid[FID_TAIL];
    // The watchdog has already seen TIMEOUT-1 stalled cycles; this one is the last.
    release_to   = (state_q == ST_LOCKED) && !xfer && (wd_q == TW'(TIMEOUT - 1));
  end

  // Grant, pointer, watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(P_S);
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= release_to;
      if (grant_now) begin
        grant_q <= {{(NPORTS-1){1'b0}}, 1'b1} << win_idx;
        idx_q   <= win_idx;
      end else if (release_tail || release_to) begin
        grant_q <= '0;
        idx_q   <= '0;
        ptr_q   <= idx_q;
      end
      if (grant_now || xfer || release_to) wd_q <= '0;
      else if (state_q == ST_LOCKED)       wd_q <= wd_q + TW'(1);
    end
  end

  // Credit counter; xfer never fires at zero, so only the top needs saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= CW'(CREDITS);
      cerr_q    <= 1'b0;
    end else begin
      cerr_q <= 1'b0;
      if (xfer && !bus.credit_in) begin
        credits_q <= credits_q - CW'(1);
      end else if (!xfer && bus.credit_in) begin
        if (credits_q == CW'(CREDITS)) cerr_q    <= 1'b1;
        else                           credits_q <= credits_q + CW'(1);
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.xfer        = xfer;
  assign bus.credits     = credits_q;
  assign bus.timeout_err = terr_q;
  assign bus.credit_err  = cerr_q;
  assign bus.state       = state_q;

endmodule
